// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

  // Widest product overflowCheck can inspect; products are zero-extended to this width.
  localparam int MAX_PRODUCT_W = 256;

  // Width of the step counter, which counts down from n/k-1 to 0.
  function automatic int countWidth(input int n, input int k);
    return (n / k > 1) ? $clog2(n / k) : 1;
  endfunction

  // Unsigned: any of bits [2n-1:n] set. Signed: bits [2n-1:n-1] not all equal.
  function automatic logic overflowCheck(input logic [MAX_PRODUCT_W-1:0] prodIn,
                                         input int n, input logic isSigned);
    logic upperAny;
    logic signMismatch;
    upperAny     = 1'b0;
    signMismatch = 1'b0;
    for (int i = 0; i < MAX_PRODUCT_W; i++) begin
      if (i >= n && i < 2 * n && prodIn[i]) upperAny = 1'b1;
      if (i >= n - 1 && i < 2 * n && prodIn[i] != prodIn[2 * n - 1]) signMismatch = 1'b1;
    end
    return isSigned ? signMismatch : upperAny;
  endfunction

endpackage

// File: rtl/mult_step_unit.sv
// One shift-add step: adds multiplicand x (K low multiplier bits) into the accumulator.
module mult_step_unit #(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic [2*N-1:0] multiplicand,
  input  logic [K-1:0]   mulBits,
  input  logic [2*N-1:0] acc,
  output logic [2*N-1:0] accNext
);

  logic [2*N-1:0] partial;

  always_comb begin
    partial = '0;
    for (int j = 0; j < K; j++) begin
      if (mulBits[j]) partial = partial + (multiplicand << j);
    end
    accNext = acc + partial;
  end

endmodule

// File: rtl/sequential_multiplier_integrated.sv
// Multi-cycle signed/unsigned multiplier with valid/ready handshakes on both sides.
module sequential_multiplier_integrated
  import mult_pkg::*;
#(
  parameter int N              = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           clear,
  input  logic           inValid,
  output logic           inReady,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signedMode,
  output logic           outValid,
  input  logic           outReady,
  output logic [2*N-1:0] product,
  output logic           overflow
);

  localparam int K     = BITS_PER_CYCLE;
  localparam int STEPS = N / K;
  localparam int CW    = countWidth(N, K);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS - 1);

  if (N < 2 || K < 1 || (N % K) != 0 || 2 * N > MAX_PRODUCT_W) begin : gBadParams
    $error("sequential_multiplier_integrated: BITS_PER_CYCLE must divide N, N >= 2");
  end

  state_e         state, nextState;
  logic           armed;
  logic [CW-1:0]  count;
  logic [2*N-1:0] mcand, acc, accNext, prodFix;
  logic [N-1:0]   mplier;
  logic           negate, signedQ, accept, ovfFix;
  logic           aNeg, bNeg;
  logic [N:0]     aExt, bExt, magA, magB;

  // inReady stays low until the first edge after reset release.
  assign inReady = armed && (state == IDLE);
  assign accept  = inValid && inReady && !clear;

  always_comb begin
    aNeg = signedMode & a[N-1];
    bNeg = signedMode & b[N-1];
    aExt = {aNeg, a};
    bExt = {bNeg, b};
    magA = aNeg ? -aExt : aExt;
    magB = bNeg ? -bExt : bExt;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = BUSY;
      BUSY: if (count == '0) nextState = FIX;
      FIX:  nextState = DONE;
      DONE: if (outReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (clear) nextState = IDLE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      armed <= 1'b0;
      count <= '0;
    end else begin
      state <= nextState;
      armed <= 1'b1;
      if (accept) count <= CNT_LOAD;
      else if (state == BUSY) count <= count - 1'b1;
    end
  end

  mult_step_unit #(.N(N), .K(K)) uStep (
    .multiplicand (mcand),
    .mulBits      (mplier[K-1:0]),
    .acc          (acc),
    .accNext      (accNext)
  );

  // Operand and accumulator registers are pure datapath and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand   <= {{(N-1){1'b0}}, magA};
      mplier  <= magB[N-1:0];
      acc     <= '0;
      negate  <= aNeg ^ bNeg;
      signedQ <= signedMode;
    end else if (state == BUSY) begin
      acc    <= accNext;
      mcand  <= mcand << K;
      mplier <= mplier >> K;
    end
  end

  // The wide negate lives only in FIX, off the per-step add path.
  assign prodFix = negate ? -acc : acc;
  assign ovfFix  = overflowCheck(MAX_PRODUCT_W'(prodFix), N, signedQ);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      product  <= '0;
      overflow <= 1'b0;
      outValid <= 1'b0;
    end else if (clear) begin
      product  <= '0;
      overflow <= 1'b0;
      outValid <= 1'b0;
    end else if (state == FIX) begin
      product  <= prodFix;
      overflow <= ovfFix;
      outValid <= 1'b1;
    end else if (state == DONE && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sequential_multiplier_integrated.sv
// Directed bench: N=8/K=1 and N=32/K=4 instances against hand-computed products.
module tb_sequential_multiplier_integrated;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN;
  logic        clear8, inValid8, inReady8, signed8, outValid8, outReady8, ovf8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        clear32, inValid32, inReady32, signed32, outValid32, outReady32, ovf32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int nChecks = 0;
  int nPass   = 0;

  sequential_multiplier_integrated #(.N(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .resetN(resetN), .clear(clear8), .inValid(inValid8), .inReady(inReady8),
    .a(a8), .b(b8), .signedMode(signed8), .outValid(outValid8), .outReady(outReady8),
    .product(prod8), .overflow(ovf8)
  );

  sequential_multiplier_integrated #(.N(32), .BITS_PER_CYCLE(4)) dut32 (
    .clk(clk), .resetN(resetN), .clear(clear32), .inValid(inValid32), .inReady(inReady32),
    .a(a32), .b(b32), .signedMode(signed32), .outValid(outValid32), .outReady(outReady32),
    .product(prod32), .overflow(ovf32)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic runOp8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [15:0] expP, input logic expO);
    int edges;
    @(negedge clk);
    checkVal({tag, "_ready"}, 64'(inReady8), 64'd1);
    a8 = a; b8 = b; signed8 = sm; inValid8 = 1'b1;
    @(posedge clk); #1 inValid8 = 1'b0;
    edges = 0;
    while (!outValid8 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    checkVal({tag, "_latency"}, 64'(edges), 64'd9);
    checkVal({tag, "_product"}, 64'(prod8), 64'(expP));
    checkVal({tag, "_overflow"}, 64'(ovf8), 64'(expO));
    @(negedge clk) outReady8 = 1'b1;
    @(posedge clk); #1 outReady8 = 1'b0;
    checkVal({tag, "_consumed"}, 64'(outValid8), 64'd0);
    checkVal({tag, "_idle"}, 64'(inReady8), 64'd1);
  endtask

  task automatic runOp32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input logic [63:0] expP, input logic expO);
    int edges;
    @(negedge clk);
    a32 = a; b32 = b; signed32 = sm; inValid32 = 1'b1;
    @(posedge clk); #1 inValid32 = 1'b0;
    edges = 0;
    while (!outValid32 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    checkVal({tag, "_latency"}, 64'(edges), 64'd9);
    checkVal({tag, "_product"}, prod32, expP);
    checkVal({tag, "_overflow"}, 64'(ovf32), 64'(expO));
    @(negedge clk) outReady32 = 1'b1;
    @(posedge clk); #1 outReady32 = 1'b0;
    checkVal({tag, "_consumed"}, 64'(outValid32), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int edges;
    resetN = 1'b0;
    clear8 = 0; inValid8 = 0; signed8 = 0; outReady8 = 0; a8 = '0; b8 = '0;
    clear32 = 0; inValid32 = 0; signed32 = 0; outReady32 = 0; a32 = '0; b32 = '0;

    // Reset state and inReady rising one edge after release
    #12;
    checkVal("rst_outValid", 64'(outValid8), 64'd0);
    checkVal("rst_inReady", 64'(inReady8), 64'd0);
    checkVal("rst_product", 64'(prod8), 64'd0);
    checkVal("rst_overflow", 64'(ovf8), 64'd0);
    checkVal("rst_inReady32", 64'(inReady32), 64'd0);
    @(negedge clk) resetN = 1'b1;
    #1 checkVal("rel_inReady_before_edge", 64'(inReady8), 64'd0);
    @(posedge clk); #1 checkVal("rel_inReady_after_edge", 64'(inReady8), 64'd1);

    // Main function, N=8 K=1
    runOp8("u200x3", 8'd200, 8'd3, 1'b0, 16'h0258, 1'b1);
    runOp8("sNeg7x6", 8'hF9, 8'h06, 1'b1, 16'hFFD6, 1'b0);
    runOp8("sMinxMin", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    runOp8("u80x80", 8'h80, 8'h80, 1'b0, 16'h4000, 1'b1);
    runOp8("uFFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
    runOp8("sM1xM1", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
    runOp8("u15x15", 8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0);
    runOp8("s127xM1", 8'h7F, 8'hFF, 1'b1, 16'hFF81, 1'b0);
    runOp8("sMinx1", 8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);

    // Backpressure with new offers while the result waits
    @(negedge clk); a8 = 8'd200; b8 = 8'd3; signed8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk); #1 inValid8 = 1'b0;
    edges = 0;
    while (!outValid8 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("bp_product", 64'(prod8), 64'h0258);
      checkVal("bp_overflow", 64'(ovf8), 64'd1);
      checkVal("bp_outValid", 64'(outValid8), 64'd1);
      checkVal("bp_inReady", 64'(inReady8), 64'd0);
      a8 = 8'd5; b8 = 8'd5; inValid8 = 1'b1;
    end
    @(negedge clk); inValid8 = 1'b0; outReady8 = 1'b1;
    @(posedge clk); #1 outReady8 = 1'b0;
    checkVal("bp_release_outValid", 64'(outValid8), 64'd0);
    checkVal("bp_release_idle", 64'(inReady8), 64'd1);
    repeat (12) @(posedge clk);
    #1 checkVal("bp_no_second_accept", 64'(outValid8), 64'd0);

    // clear mid-BUSY together with inValid
    @(negedge clk); a8 = 8'h0F; b8 = 8'h0F; signed8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk); #1 inValid8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); clear8 = 1'b1; inValid8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk); #1 clear8 = 1'b0; inValid8 = 1'b0;
    checkVal("clr_idle", 64'(inReady8), 64'd1);
    checkVal("clr_outValid", 64'(outValid8), 64'd0);
    checkVal("clr_product", 64'(prod8), 64'd0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (outValid8) seen = 1'b1;
    end
    checkVal("clr_outValid_never", 64'(seen), 64'd0);
    // clear beats a simultaneous accept in IDLE
    @(negedge clk); clear8 = 1'b1; inValid8 = 1'b1;
    @(posedge clk); #1 clear8 = 1'b0; inValid8 = 1'b0;
    checkVal("clr_blocks_accept", 64'(inReady8), 64'd1);
    runOp8("afterClr", 8'hF9, 8'h06, 1'b1, 16'hFFD6, 1'b0);

    // Asynchronous reset pulse mid-BUSY
    @(negedge clk); a8 = 8'd200; b8 = 8'd3; signed8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk); #1 inValid8 = 1'b0;
    repeat (2) @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    checkVal("arst_outValid", 64'(outValid8), 64'd0);
    checkVal("arst_inReady", 64'(inReady8), 64'd0);
    checkVal("arst_product", 64'(prod8), 64'd0);
    checkVal("arst_overflow", 64'(ovf8), 64'd0);
    #3 resetN = 1'b1;
    #1 checkVal("arst_rel_before_edge", 64'(inReady8), 64'd0);
    @(posedge clk); #1 checkVal("arst_rel_after_edge", 64'(inReady8), 64'd1);
    runOp8("afterRst", 8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0);

    // N=32, K=4
    runOp32("w32_uMax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
    runOp32("w32_sMin", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
    runOp32("w32_sM3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1, 1'b0);
    runOp32("w32_uSmall", 32'd65536, 32'd65535, 1'b0, 64'h00000000FFFF0000, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/sequential_multiplier_integrated.md
# sequential_multiplier_integrated

Parametrised, multi-cycle integer multiplier with valid/ready handshakes on both sides. It replaces the single-cycle multiplier and its three enable-controlled registers. It accepts an operand pair, retires BITS_PER_CYCLE multiplier bits per cycle with shift-add, applies signed correction and holds the registered full-width product until it is consumed. It sits between an operand producer and a result consumer in the multiplier test harness and trades latency for area at large N.

## Interface
- N, 32, operand width; N ≥ 2.
- BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle; must divide N (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- inValid  in  1  operand pair offered.
- inReady  out  1  block can accept operands.
- a, b  in  N  operands, sampled on the accept edge (inValid & inReady).
- signedMode  in  1  sampled on the accept edge: 1 = two's-complement, 0 = unsigned.
- outValid  out  1  product and overflow are valid.
- outReady  in  1  consumer accepts the result.
- product  out  2N  full product, registered.
- overflow  out  1  product does not fit in N bits for the sampled mode.

## Operation
- States: IDLE → BUSY → FIX → DONE → IDLE.
- IDLE:
  - inReady = 1. On the accept edge, latch |a| and |b| (magnitudes in signed mode, raw values in unsigned mode).
  - Latch negate = signedMode & (a[N-1] ^ b[N-1]).
  - Clear the accumulator, load count = N/BITS_PER_CYCLE − 1, go to BUSY.
- BUSY:
  - Each cycle, add the partial product of the multiplicand and the low BITS_PER_CYCLE bits of the multiplier into the accumulator.
  - Shift the multiplier right by BITS_PER_CYCLE and decrement count. When count = 0, go to FIX.
- FIX (1 cycle):
  - product ← negate ? −acc : acc (2N-bit two's complement).
  - Compute overflow. Unsigned: product[2N-1:N] ≠ 0. Signed: bits product[2N-1:N-1] not all equal.
  - Set outValid, go to DONE.
- DONE: product and overflow are held stable while outValid = 1 & outReady = 0. On outValid & outReady, clear outValid and go to IDLE.
- inReady = 1 only in IDLE. inValid in any other state is ignored, with no queueing.
- Magnitude of the most negative operand (−2^(N-1)) is computed in N+1 bits, so the full-range product is exact.
- clear: in any state, go to IDLE on the next edge and drop outValid. product and overflow go to 0. clear takes priority over a simultaneous accept or outReady.
- resetN low: immediately, outValid = 0, inReady = 0, product = 0, overflow = 0, state = IDLE. inReady rises on the first clk edge after resetN deasserts.

## Timing
- Latency: outValid rises L = N/BITS_PER_CYCLE + 1 edges after the accept edge (N=32, K=1: 33).
- Minimum initiation interval: L + 2 cycles (accept, L cycles of compute, one consume cycle, return to IDLE).
- All outputs are registered except inReady, which is decoded from the registered state. There are no combinational paths from inputs to outputs.
- The critical path is one (N+1)×BITS_PER_CYCLE partial-product add into a 2N-bit accumulator. The 2N-bit negate is isolated in FIX.

## Structure
- Package mult_pkg: state enum (IDLE, BUSY, FIX, DONE), a clog2-based count-width constant, and function overflowCheck(product, signedMode).
- Sub-module mult_step_unit: combinational, takes the multiplicand, the low BITS_PER_CYCLE multiplier bits and the accumulator, and returns the next accumulator. Instantiated once.
- The top level holds the FSM, counter, operand registers, sign logic and output registers.

## Test plan
- N=8, K=1, unsigned: a=200, b=3 → product=0x0258, overflow=1; outValid exactly 9 edges after accept.
- N=8, signed: a=0xF9 (−7), b=0x06 → product=0xFFD6 (−42), overflow=0. Then a=0x80, b=0x80 → product=0x4000, overflow=1.
- N=32, K=4, unsigned: a=b=0xFFFFFFFF → product=0xFFFFFFFE00000001, latency 9; rejects BITS_PER_CYCLE=3 at elaboration.
- Backpressure: hold outReady=0 for 5 cycles while driving new inValid → product/overflow stable, inReady=0, no second accept; outReady=1 → IDLE next edge.
- clear asserted mid-BUSY together with inValid → IDLE next edge, outValid never rises, no accept that cycle. A following op completes correctly.
- resetN pulsed low mid-BUSY, asynchronous to clk → outputs 0 immediately; inReady=1 one edge after release. A new op yields the correct product.
